// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a single shared multiplier.
// One operation is in flight at a time; the product is held until its owner takes it.
module mul_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  resp0_valid,
    output logic                  resp1_valid,
    output logic [RES_WIDTH-1:0]  resp_data,
    input  logic                  resp0_ready,
    input  logic                  resp1_ready,
    output logic                  mul_wr_en,
    output logic [DATA_WIDTH-1:0] mul_wr_data_1,
    output logic [DATA_WIDTH-1:0] mul_wr_data_2,
    input  logic                  mul_wr_ready,
    output logic                  mul_rd_en,
    input  logic                  mul_rd_ready,
    input  logic                  mul_rd_val,
    input  logic [RES_WIDTH-1:0]  mul_rd_data,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        READ,
        HOLD
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  owner_q;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [RES_WIDTH-1:0]  res_q;
    logic                  can_grant;
    logic                  grant_sel;
    logic                  owner_ready;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_sel   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        can_grant   = reset && (state == IDLE) && mul_wr_ready && (req0_valid || req1_valid);
        owner_ready = owner_q ? resp1_ready : resp0_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        owner_q    <= grant_sel;
                        last_grant <= grant_sel;
                        op_a       <= grant_sel ? req1_a : req0_a;
                        op_b       <= grant_sel ? req1_b : req0_b;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mul_rd_ready) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (mul_rd_val) begin
                        res_q <= mul_rd_data;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (owner_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are forced low while reset is asserted, whatever the state register holds.
    assign req0_ready    = can_grant && !grant_sel;
    assign req1_ready    = can_grant && grant_sel;
    assign mul_wr_en     = reset && (state == ISSUE);
    assign mul_rd_en     = reset && (state == WAIT) && mul_rd_ready;
    assign resp0_valid   = reset && (state == HOLD) && !owner_q;
    assign resp1_valid   = reset && (state == HOLD) && owner_q;
    assign busy          = reset && (state != IDLE);
    assign owner         = owner_q;
    assign resp_data     = res_q;
    assign mul_wr_data_1 = op_a;
    assign mul_wr_data_2 = op_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: stub multiplier, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mul_arbiter;
    localparam int DW = 16;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [RW-1:0] resp_data;
    logic          resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic          mul_wr_en, mul_rd_en, busy, owner;
    logic [DW-1:0] mul_wr_data_1, mul_wr_data_2;
    logic          mul_wr_ready;
    logic          mul_rd_ready = 1'b0, mul_rd_val = 1'b0;
    logic [RW-1:0] mul_rd_data = '0;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.DATA_WIDTH(DW), .RES_WIDTH(RW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .mul_wr_en(mul_wr_en), .mul_wr_data_1(mul_wr_data_1), .mul_wr_data_2(mul_wr_data_2),
        .mul_wr_ready(mul_wr_ready), .mul_rd_en(mul_rd_en), .mul_rd_ready(mul_rd_ready),
        .mul_rd_val(mul_rd_val), .mul_rd_data(mul_rd_data),
        .busy(busy), .owner(owner)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub multiplier: busy from operand write until its result has been read out.
    bit            st_busy = 0, rd_pending = 0, rnd_lat = 0;
    int            st_cnt = 0, val_wait = 0, fixed_lat = 4;
    logic [RW-1:0] st_prod = '0;
    assign mul_wr_ready = !st_busy;

    always begin
        logic w, r, rs;
        logic [DW-1:0] wa, wb;
        @(posedge clk);
        w = mul_wr_en; r = mul_rd_en; rs = reset; wa = mul_wr_data_1; wb = mul_wr_data_2;
        #1;
        if (!rs) begin
            st_busy = 0; rd_pending = 0; mul_rd_ready = 0; mul_rd_val = 0;
        end else begin
            if (mul_rd_val) begin
                mul_rd_val = 0; st_busy = 0; mul_rd_data = $urandom;
            end
            if (w) begin
                st_busy = 1;
                st_cnt  = rnd_lat ? int'($urandom_range(1, 5)) : fixed_lat;
                st_prod = RW'(wa) * RW'(wb);
            end else if (st_busy && st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) mul_rd_ready = 1;
            end
            if (r) begin
                mul_rd_ready = 0; rd_pending = 1;
                val_wait = rnd_lat ? int'($urandom_range(0, 2)) : 0;
            end
            if (rd_pending) begin
                if (val_wait == 0) begin
                    mul_rd_val = 1; mul_rd_data = st_prod; rd_pending = 0;
                end else begin
                    val_wait--;
                end
            end
        end
    end

    // Reference model: at most one job in flight, tracked as a set of milestones.
    bit            m_active = 0, m_issued = 0, m_rdreq = 0, m_captured = 0;
    bit            m_owner = 0, m_last = 1;
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic [RW-1:0] m_prod = '0;

    int            grant_q[$], resp_idx_q[$];
    logic [RW-1:0] resp_data_q[$];
    int            grant_cyc = 0, wr_cyc = 0;

    always @(negedge clk) begin
        bit win, gr, act;
        cyc++;
        if (req0_ready) begin grant_q.push_back(0); grant_cyc = cyc; end
        if (req1_ready) begin grant_q.push_back(1); grant_cyc = cyc; end
        if (mul_wr_en) wr_cyc = cyc;
        if (resp0_valid && resp0_ready) begin resp_idx_q.push_back(0); resp_data_q.push_back(resp_data); end
        if (resp1_valid && resp1_ready) begin resp_idx_q.push_back(1); resp_data_q.push_back(resp_data); end

        win = (req0_valid && req1_valid) ? !m_last : req1_valid;
        gr  = reset && !m_active && mul_wr_ready && (req0_valid || req1_valid);
        act = reset && m_active;
        if (chk_en) begin
            checkOutput("req0_ready", req0_ready, gr && !win);
            checkOutput("req1_ready", req1_ready, gr && win);
            checkOutput("busy", busy, act);
            checkOutput("mul_wr_en", mul_wr_en, act && !m_issued);
            checkOutput("mul_rd_en", mul_rd_en, act && m_issued && !m_rdreq && mul_rd_ready);
            checkOutput("resp0_valid", resp0_valid, act && m_captured && !m_owner);
            checkOutput("resp1_valid", resp1_valid, act && m_captured && m_owner);
            checkOutput("resp_data", resp_data, m_prod);
            checkOutput("mul_wr_data_1", mul_wr_data_1, m_a);
            checkOutput("mul_wr_data_2", mul_wr_data_2, m_b);
            if (act) checkOutput("owner", owner, m_owner);
        end

        if (!reset) begin
            m_active = 0; m_last = 1; m_owner = 0; m_a = '0; m_b = '0; m_prod = '0;
        end else if (!m_active) begin
            if (gr) begin
                m_active = 1; m_issued = 0; m_rdreq = 0; m_captured = 0;
                m_owner = win; m_last = win;
                m_a = win ? req1_a : req0_a;
                m_b = win ? req1_b : req0_b;
            end
        end else if (!m_issued) begin
            m_issued = 1;
        end else if (!m_rdreq) begin
            if (mul_rd_ready) m_rdreq = 1;
        end else if (!m_captured) begin
            if (mul_rd_val) begin
                m_captured = 1;
                m_prod = RW'(m_a) * RW'(m_b);
            end
        end else if (m_owner ? resp1_ready : resp0_ready) begin
            m_active = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_q.delete(); resp_idx_q.delete(); resp_data_q.delete();
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return req0_ready;
            1: return req1_ready;
            2: return resp0_valid && resp0_ready;
            3: return resp1_valid && resp1_ready;
            4: return mul_wr_en;
            5: return resp0_valid;
            6: return (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sig(which)) begin seen = 1; break; end
        end
        checkOutput({"timeout ", name}, seen, 1);
        tick();
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            reset       = ($urandom_range(0, 299) != 0);
            req0_valid  = $urandom_range(0, 1);
            req1_valid  = $urandom_range(0, 1);
            req0_a      = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom);
            req0_b      = DW'($urandom);
            req1_a      = DW'($urandom);
            req1_b      = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom);
            resp0_ready = ($urandom_range(0, 9) < 7);
            resp1_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_grants[6] = '{0, 1, 0, 1, 0, 1};
        reset = 0;
        @(posedge clk); #1;
        chk_en = 1;
        req0_valid = 1; req0_a = 1; req0_b = 1;
        @(negedge clk);
        checkOutput("req0_ready under reset", req0_ready, 0);
        checkOutput("busy under reset", busy, 0);
        tick();
        req0_valid = 0;
        reset = 1;
        tick();

        // Single request, 4-cycle multiplier
        clear_logs();
        req0_valid = 1; req0_a = 7; req0_b = 6;
        wait_sig(0, "grant req0");
        req0_valid = 0; req0_a = 99; req0_b = 99;
        wait_sig(2, "resp0");
        checkOutput("single grant idx", grant_q.size() > 0 ? grant_q[0] : -1, 0);
        checkOutput("single product", resp_data_q.size() > 0 ? resp_data_q[0] : '1, 42);
        checkOutput("single resp idx", resp_idx_q.size() > 0 ? resp_idx_q[0] : -1, 0);
        checkOutput("grant to wr_en", wr_cyc - grant_cyc, 1);

        // Tie after reset, then fairness over six grants
        reset = 0; tick(); reset = 1;
        clear_logs();
        req0_valid = 1; req0_a = 3; req0_b = 5;
        req1_valid = 1; req1_a = 9; req1_b = 9;
        for (int k = 0; k < 6; k++) wait_sig(6, "tie response");
        req0_valid = 0; req1_valid = 0;
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("grant seq %0d", k), grant_q.size() > k ? grant_q[k] : -1, exp_grants[k]);
        checkOutput("tie first product", resp_data_q.size() > 0 ? resp_data_q[0] : '1, 15);
        checkOutput("tie second product", resp_data_q.size() > 1 ? resp_data_q[1] : '1, 81);
        checkOutput("tie second idx", resp_idx_q.size() > 1 ? resp_idx_q[1] : -1, 1);
        tick();

        // Backpressure in HOLD, then back-to-back grant
        clear_logs();
        resp0_ready = 0;
        req0_valid = 1; req0_a = 7; req0_b = 6;
        wait_sig(0, "bp grant");
        req0_valid = 0;
        wait_sig(5, "bp resp0_valid");
        req1_valid = 1; req1_a = 2; req1_b = 3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bp resp0_valid", resp0_valid, 1);
            checkOutput("bp resp_data", resp_data, 42);
            checkOutput("bp busy", busy, 1);
            checkOutput("bp no grant", req1_ready, 0);
        end
        tick();
        resp0_ready = 1;
        @(negedge clk);
        checkOutput("bp release handshake", resp0_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("bp idle after release", busy, 0);
        checkOutput("bp back-to-back grant", req1_ready, 1);
        tick();
        req1_valid = 0;
        wait_sig(3, "bp resp1");
        checkOutput("bp req1 product", resp_data_q.size() > 1 ? resp_data_q[1] : '1, 6);

        // Largest operands
        clear_logs();
        req1_valid = 1; req1_a = '1; req1_b = '1;
        wait_sig(1, "max grant");
        req1_valid = 0;
        wait_sig(3, "max resp1");
        checkOutput("max product", resp_data_q.size() > 0 ? resp_data_q[0] : '0, 32'hFFFE_0001);

        // Reset while waiting on the multiplier
        fixed_lat = 6;
        req0_valid = 1; req0_a = 5; req0_b = 5;
        wait_sig(4, "wait wr_en");
        req0_valid = 0;
        tick();
        reset = 0; tick(); reset = 1;
        @(negedge clk);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort resp0_valid", resp0_valid, 0);
        tick();
        clear_logs();
        fixed_lat = 4;
        req1_valid = 1; req1_a = 11; req1_b = 12;
        wait_sig(1, "post-abort grant");
        req1_valid = 0;
        wait_sig(3, "post-abort resp1");
        checkOutput("post-abort responses", resp_idx_q.size(), 1);
        checkOutput("post-abort product", resp_data_q.size() > 0 ? resp_data_q[0] : '0, 132);

        // Randomized traffic against the model
        rnd_lat = 1;
        applyStimulus(3000);
        reset = 1; req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
